// File: rtl/seq_slice_adder.sv
// seq_slice_adder: WIDTH-bit add/subtract evaluated one SLICE-bit ripple slice per clock,
// with a registered carry linking slices and a start/busy/done handshake.
module seq_slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             OV
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_partial;
    logic             r_carry;
    logic [CW-1:0]    r_sliceIdx;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_ov;

    logic [SLICE-1:0] w_sliceSum;
    logic             w_sliceCo;
    logic             w_msbCarryIn;
    logic [WIDTH-1:0] w_sliceWide;
    logic [WIDTH-1:0] w_nextPartial;

    // Operands shift right each cycle, so the active slice always sits in the low SLICE bits.
    always_comb begin : ripple
        logic carry;
        carry        = r_carry;
        w_sliceSum   = '0;
        w_msbCarryIn = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                w_msbCarryIn = carry;
            end
            w_sliceSum[i] = r_opA[i] ^ r_opB[i] ^ carry;
            carry         = (r_opA[i] & r_opB[i]) | (carry & (r_opA[i] ^ r_opB[i]));
        end
        w_sliceCo = carry;
    end

    // Finished slices enter the partial result from the top and drift down to their place.
    assign w_sliceWide   = WIDTH'(w_sliceSum);
    assign w_nextPartial = (r_partial >> SLICE) | (w_sliceWide << (WIDTH - SLICE));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_opA      <= '0;
            r_opB      <= '0;
            r_partial  <= '0;
            r_carry    <= 1'b0;
            r_sliceIdx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_co       <= 1'b0;
            r_ov       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, FIN: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_opA      <= A;
                        r_opB      <= SUB ? ~B : B;
                        r_carry    <= Ci ^ SUB;
                        r_partial  <= '0;
                        r_sliceIdx <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_opA      <= r_opA >> SLICE;
                    r_opB      <= r_opB >> SLICE;
                    r_carry    <= w_sliceCo;
                    r_partial  <= w_nextPartial;
                    r_sliceIdx <= r_sliceIdx + 1'b1;
                    if (r_sliceIdx == LAST_IDX) begin
                        // Last slice: its top carry-in/out are the word's MSB carries.
                        r_sum   <= w_nextPartial;
                        r_co    <= w_sliceCo;
                        r_ov    <= w_sliceCo ^ w_msbCarryIn;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign S    = r_sum;
    assign Co   = r_co;
    assign OV   = r_ov;

endmodule
